// File: rtl/generic_memory_pkg.sv
// Shared widths, helpers and request/response types for the generic_memory front-end.
package generic_memory_pkg;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned be_width(input int unsigned dw, input int unsigned bw);
      return dw / bw;
   endfunction

   localparam int unsigned ADDR_WIDTH    = 12;
   localparam int unsigned DATA_WIDTH    = 32;
   localparam int unsigned BYTE_WIDTH    = 8;
   localparam int unsigned BE_WIDTH      = be_width(DATA_WIDTH, BYTE_WIDTH);
   localparam int unsigned RSP_DEPTH     = 2;
   localparam int unsigned RSP_PTR_WIDTH = ptr_width(RSP_DEPTH);

   typedef struct packed {
      logic                  we;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [BE_WIDTH-1:0]   be;
   } mem_req_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] rdata;
   } mem_rsp_t;

endpackage

// File: rtl/mem_rsp_fifo.sv
// Register FIFO holding read data captured from the macro until the consumer takes it.
module mem_rsp_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] pop_data_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [CNT_WIDTH-1:0]  count_o
);
   import generic_memory_pkg::*;

   localparam int unsigned PTR_WIDTH = ptr_width(DEPTH);

   logic [DATA_WIDTH-1:0] storage_q [DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;

   // Wrap explicitly so non-power-of-two depths work.
   function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
      return (ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_d = next_ptr(rd_ptr_q);
      unique case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push_i) storage_q[wr_ptr_q] <= push_data_i;
   end

   assign pop_data_o = storage_q[rd_ptr_q];
   assign full_o     = (count_q == CNT_WIDTH'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;

endmodule

// File: rtl/generic_memory_req_adapter.sv
// Valid/ready front-end for the generic_memory macro: pin drive, INITN sequencing,
// and a credit-checked response FIFO so read data survives consumer back-pressure.
module generic_memory_req_adapter #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BYTE_WIDTH = 8,
   parameter int unsigned BE_WIDTH   = DATA_WIDTH / BYTE_WIDTH,
   parameter int unsigned RSP_DEPTH  = 2
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   input  logic [BE_WIDTH-1:0]   req_be_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  mem_initn_o,
   output logic                  mem_cen_o,
   output logic                  mem_wen_o,
   output logic [ADDR_WIDTH-1:0] mem_a_o,
   output logic [DATA_WIDTH-1:0] mem_d_o,
   output logic [BE_WIDTH-1:0]   mem_ben_o,
   input  logic [DATA_WIDTH-1:0] mem_q_i
);
   localparam int unsigned CNT_WIDTH = $clog2(RSP_DEPTH + 1);
   localparam int unsigned CRD_WIDTH = CNT_WIDTH + 1;

   logic                 initn_q;
   logic                 rd_pending_q, rd_pending_d;
   logic [CNT_WIDTH-1:0] fifo_count;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 push;
   logic                 pop;
   logic                 accept;
   logic [CRD_WIDTH-1:0] slots_used;
   logic                 read_credit;

   // Every accepted-but-unpopped read owns a slot, including the one still in the macro.
   always_comb begin
      pop         = rsp_valid_o & rsp_ready_i;
      slots_used  = CRD_WIDTH'(fifo_count) + CRD_WIDTH'(rd_pending_q) - CRD_WIDTH'(pop);
      read_credit = (slots_used < CRD_WIDTH'(RSP_DEPTH));
      req_ready_o = initn_q & (req_we_i | read_credit);
      accept      = req_valid_i & req_ready_o;
      rd_pending_d = accept & ~req_we_i;
      push        = rd_pending_q & ~fifo_full;
   end

   assign mem_initn_o = initn_q;
   assign mem_cen_o   = ~accept;
   assign mem_wen_o   = ~req_we_i;
   assign mem_a_o     = req_addr_i;
   assign mem_d_o     = req_wdata_i;
   assign mem_ben_o   = req_we_i ? ~req_be_i : '1;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         initn_q      <= 1'b0;
         rd_pending_q <= 1'b0;
      end else begin
         initn_q      <= 1'b1;
         rd_pending_q <= rd_pending_d;
      end
   end

   mem_rsp_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (RSP_DEPTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_rsp_fifo (
      .CLK         (CLK),
      .RSTN        (RSTN),
      .push_i      (push),
      .push_data_i (mem_q_i),
      .pop_i       (pop),
      .pop_data_o  (rsp_rdata_o),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign rsp_valid_o = ~fifo_empty;

endmodule
